// File: rtl/mc_control_unit_if.sv
// Bundle between the multi-cycle MIPS control unit and its datapath/memory.
// The master side is the control FSM; the slave side is the datapath and memory.
interface mc_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       ir_opcode;
    logic [5:0]       ir_funct;
    logic             mem_ready;
    logic             zero_flag;
    logic             overflow;
    logic [5:0]       alu_op;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             trap;
    logic             trap_cause;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  ir_opcode, ir_funct, mem_ready, zero_flag, overflow,
        output alu_op, alu_src_a, alu_src_b, pc_en, pc_src, ir_write, mem_read, mem_write,
               iord, reg_write, reg_dst, mem_to_reg, trap, trap_cause, state, instret
    );

    modport slave (
        output ir_opcode, ir_funct, mem_ready, zero_flag, overflow,
        input  alu_op, alu_src_a, alu_src_b, pc_en, pc_src, ir_write, mem_read, mem_write,
               iord, reg_write, reg_dst, mem_to_reg, trap, trap_cause, state, instret
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the ALU opcode and datapath enables, and raises traps on illegal ops or overflow.
module mc_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mc_control_unit_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    // Returns {valid, alu_op} for ALU-class instructions; valid=0 for anything else.
    function automatic logic [6:0] alu_decode(input logic [5:0] op, input logic [5:0] fn);
        logic [6:0] res;
        res = 7'd0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    6'b100000: res = {1'b1, 6'd0};
                    6'b100010: res = {1'b1, 6'd1};
                    6'b011000: res = {1'b1, 6'd2};
                    6'b100100: res = {1'b1, 6'd3};
                    6'b100101: res = {1'b1, 6'd4};
                    6'b100110: res = {1'b1, 6'd5};
                    6'b100111: res = {1'b1, 6'd6};
                    default:   res = 7'd0;
                endcase
            end
            OP_ADDI: res = {1'b1, 6'd7};
            OP_ANDI: res = {1'b1, 6'd10};
            OP_ORI:  res = {1'b1, 6'd11};
            OP_XORI: res = {1'b1, 6'd12};
            default: res = 7'd0;
        endcase
        return res;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] instret_r;
    logic             trap_cause_r, cause_nxt_s, retire_s;
    logic [6:0]       alu_dec_s;
    logic             is_rtype_s, ovf_op_s;

    logic [5:0] alu_op_s;
    logic       alu_src_a_s, pc_en_s, ir_write_s, mem_read_s, mem_write_s, iord_s;
    logic       reg_write_s, reg_dst_s, mem_to_reg_s, trap_s;
    logic [1:0] alu_src_b_s, pc_src_s;

    assign alu_dec_s  = alu_decode(bus.ir_opcode, bus.ir_funct);
    assign is_rtype_s = (bus.ir_opcode == OP_RTYPE);
    // Only the arithmetic add/sub/addi ops trap on overflow; logic ops and mul ignore it.
    assign ovf_op_s   = (alu_dec_s[5:0] == 6'd0) || (alu_dec_s[5:0] == 6'd1) || (alu_dec_s[5:0] == 6'd7);

    // Next-state, datapath controls, trap cause and retirement for the current state.
    always_comb begin
        state_nxt_s  = state_r;
        cause_nxt_s  = trap_cause_r;
        retire_s     = 1'b0;
        alu_op_s     = 6'd0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_en_s      = 1'b0;
        pc_src_s     = 2'b00;
        ir_write_s   = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        iord_s       = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        trap_s       = 1'b0;
        // Controls stay quiet while reset is held so a pending access is dropped at once.
        if (reset) begin
            state_nxt_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_read_s  = 1'b1;
                    alu_src_b_s = 2'b01;
                    if (bus.mem_ready) begin
                        ir_write_s  = 1'b1;
                        pc_en_s     = 1'b1;
                        state_nxt_s = S_DECODE;
                    end else begin
                        state_nxt_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    alu_src_b_s = 2'b11;
                    case (bus.ir_opcode)
                        OP_LW, OP_SW: state_nxt_s = S_MEM_ADDR;
                        OP_BEQ:       state_nxt_s = S_BRANCH;
                        OP_J:         state_nxt_s = S_JUMP;
                        default: begin
                            if (alu_dec_s[6]) begin
                                state_nxt_s = S_EXEC;
                            end else begin
                                state_nxt_s = S_TRAP;
                                cause_nxt_s = 1'b0;
                            end
                        end
                    endcase
                end
                S_EXEC: begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = is_rtype_s ? 2'b00 : 2'b10;
                    alu_op_s    = alu_dec_s[5:0];
                    if (bus.overflow && ovf_op_s) begin
                        state_nxt_s = S_TRAP;
                        cause_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = S_ALU_WB;
                    end
                end
                S_ALU_WB: begin
                    reg_write_s = 1'b1;
                    reg_dst_s   = is_rtype_s;
                    retire_s    = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = 2'b10;
                    alu_op_s    = (bus.ir_opcode == OP_LW) ? 6'd14 : 6'd15;
                    state_nxt_s = (bus.ir_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_read_s  = 1'b1;
                    iord_s      = 1'b1;
                    state_nxt_s = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
                end
                S_MEM_WB: begin
                    reg_write_s  = 1'b1;
                    mem_to_reg_s = 1'b1;
                    retire_s     = 1'b1;
                    state_nxt_s  = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_write_s = 1'b1;
                    iord_s      = 1'b1;
                    retire_s    = bus.mem_ready;
                    state_nxt_s = bus.mem_ready ? S_FETCH : S_MEM_WR;
                end
                S_BRANCH: begin
                    alu_src_a_s = 1'b1;
                    alu_op_s    = 6'd16;
                    pc_src_s    = 2'b01;
                    pc_en_s     = bus.zero_flag;
                    retire_s    = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                S_JUMP: begin
                    pc_src_s    = 2'b10;
                    pc_en_s     = 1'b1;
                    retire_s    = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                S_TRAP: begin
                    trap_s      = 1'b1;
                    pc_src_s    = 2'b11;
                    pc_en_s     = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                default: state_nxt_s = S_FETCH;
            endcase
        end
    end

    // State register, retired-instruction counter and sticky trap cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_FETCH;
            instret_r    <= '0;
            trap_cause_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            trap_cause_r <= cause_nxt_s;
            if (retire_s) begin
                instret_r <= instret_r + CNT_W'(1);
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    assign bus.alu_op     = alu_op_s;
    assign bus.alu_src_a  = alu_src_a_s;
    assign bus.alu_src_b  = alu_src_b_s;
    assign bus.pc_en      = pc_en_s;
    assign bus.pc_src     = pc_src_s;
    assign bus.ir_write   = ir_write_s;
    assign bus.mem_read   = mem_read_s;
    assign bus.mem_write  = mem_write_s;
    assign bus.iord       = iord_s;
    assign bus.reg_write  = reg_write_s;
    assign bus.reg_dst    = reg_dst_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.trap       = trap_s;
    assign bus.trap_cause = trap_cause_r;
    assign bus.state      = state_r;
    assign bus.instret    = instret_r;
endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: each driven cycle pushes the expected control word,
// and a negedge monitor pops it and compares against the DUT.
module tb_mc_control_unit;
    localparam int CW = 3;

    typedef struct packed {
        logic [3:0]    st;
        logic [5:0]    alu_op;
        logic          src_a;
        logic [1:0]    src_b;
        logic          pc_en;
        logic [1:0]    pc_src;
        logic          ir_write;
        logic          mem_read;
        logic          mem_write;
        logic          iord;
        logic          reg_write;
        logic          reg_dst;
        logic          mem_to_reg;
        logic          trap;
        logic          trap_cause;
        logic [CW-1:0] instret;
    } exp_t;

    logic    clk;
    logic    reset;
    int      n_checks;
    int      n_errors;
    exp_t    sb_q[$];
    logic [CW-1:0] exp_instret;
    logic    exp_cause;

    mc_control_unit_if #(.CNT_W(CW)) bus ();
    mc_control_unit #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: compare the oldest expected word against the DUT mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [27:0] ev;
        logic [27:0] ov;
        if (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            ev = e;
            ov = {bus.state, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_en, bus.pc_src,
                  bus.ir_write, bus.mem_read, bus.mem_write, bus.iord, bus.reg_write, bus.reg_dst,
                  bus.mem_to_reg, bus.trap, bus.trap_cause, bus.instret};
            check_val("state", 32'(ov[27:24]), 32'(ev[27:24]));
            check_val("ctl", 32'(ov[23:3]), 32'(ev[23:3]));
            check_val("instret", 32'(ov[2:0]), 32'(ev[2:0]));
        end
    end

    function automatic exp_t base(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        e.trap_cause = exp_cause;
        e.instret = exp_instret;
        return e;
    endfunction

    task automatic drive(input logic rdy, input logic zf, input logic ovf, input exp_t e);
        bus.mem_ready = rdy;
        bus.zero_flag = zf;
        bus.overflow  = ovf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int waits, input logic [5:0] op, input logic [5:0] fn);
        exp_t e;
        bus.ir_opcode = op;
        bus.ir_funct  = fn;
        e = base(4'd0);
        e.mem_read = 1'b1;
        e.src_b = 2'b01;
        for (int i = 0; i < waits; i++) drive(1'b0, 1'b0, 1'b0, e);
        e.ir_write = 1'b1;
        e.pc_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, e);
        e = base(4'd1);
        e.src_b = 2'b11;
        drive(1'b1, 1'b0, 1'b0, e);
    endtask

    task automatic do_trap(input logic cause);
        exp_t e;
        exp_cause = cause;
        e = base(4'd10);
        e.trap = 1'b1;
        e.pc_src = 2'b11;
        e.pc_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, e);
    endtask

    task automatic run_alu(input logic [5:0] op, input logic [5:0] fn, input logic [5:0] code,
                           input logic ovf, input logic expect_trap);
        exp_t e;
        do_fetch(0, op, fn);
        e = base(4'd6);
        e.src_a = 1'b1;
        e.src_b = (op == 6'b000000) ? 2'b00 : 2'b10;
        e.alu_op = code;
        drive(1'b1, 1'b0, ovf, e);
        if (expect_trap) begin
            do_trap(1'b1);
        end else begin
            e = base(4'd7);
            e.reg_write = 1'b1;
            e.reg_dst = (op == 6'b000000);
            drive(1'b1, 1'b0, ovf, e);
            exp_instret = exp_instret + 3'd1;
        end
    endtask

    task automatic run_mem(input logic is_lw, input int fw, input int mw);
        exp_t e;
        do_fetch(fw, is_lw ? 6'b100011 : 6'b101011, 6'd0);
        e = base(4'd2);
        e.src_a = 1'b1;
        e.src_b = 2'b10;
        e.alu_op = is_lw ? 6'd14 : 6'd15;
        drive(1'b0, 1'b0, 1'b0, e);
        e = base(is_lw ? 4'd3 : 4'd5);
        e.iord = 1'b1;
        e.mem_read = is_lw;
        e.mem_write = !is_lw;
        for (int i = 0; i < mw; i++) drive(1'b0, 1'b0, 1'b0, e);
        drive(1'b1, 1'b0, 1'b0, e);
        if (is_lw) begin
            e = base(4'd4);
            e.reg_write = 1'b1;
            e.mem_to_reg = 1'b1;
            drive(1'b0, 1'b0, 1'b0, e);
        end
        exp_instret = exp_instret + 3'd1;
    endtask

    task automatic run_beq(input logic zf);
        exp_t e;
        do_fetch(0, 6'b000100, 6'd0);
        e = base(4'd8);
        e.src_a = 1'b1;
        e.alu_op = 6'd16;
        e.pc_src = 2'b01;
        e.pc_en = zf;
        drive(1'b1, zf, 1'b0, e);
        exp_instret = exp_instret + 3'd1;
    endtask

    task automatic run_j();
        exp_t e;
        do_fetch(0, 6'b000010, 6'd0);
        e = base(4'd9);
        e.pc_src = 2'b10;
        e.pc_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, e);
        exp_instret = exp_instret + 3'd1;
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_errors = 0;
        exp_instret = '0;
        exp_cause = 1'b0;
        reset = 1'b1;
        bus.ir_opcode = 6'd0;
        bus.ir_funct = 6'd0;
        bus.mem_ready = 1'b0;
        bus.zero_flag = 1'b0;
        bus.overflow = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, base(4'd0));
        reset = 1'b0;

        run_alu(6'b000000, 6'b100000, 6'd0, 1'b0, 1'b0);   // add
        run_mem(1'b1, 2, 2);                               // lw, 9 cycles
        run_alu(6'b001000, 6'd0, 6'd7, 1'b1, 1'b1);        // addi overflow -> trap
        run_alu(6'b000000, 6'b100100, 6'd3, 1'b1, 1'b0);   // and ignores overflow
        run_beq(1'b1);
        run_beq(1'b0);
        do_fetch(0, 6'b111111, 6'd0);
        do_trap(1'b0);
        run_alu(6'b000000, 6'b100010, 6'd1, 1'b1, 1'b1);   // sub overflow -> trap
        do_fetch(0, 6'b000000, 6'b000001);
        do_trap(1'b0);
        run_alu(6'b000000, 6'b011000, 6'd2, 1'b1, 1'b0);   // mul ignores overflow
        run_alu(6'b000000, 6'b100101, 6'd4, 1'b0, 1'b0);
        run_alu(6'b000000, 6'b100110, 6'd5, 1'b0, 1'b0);
        run_alu(6'b000000, 6'b100111, 6'd6, 1'b0, 1'b0);
        run_alu(6'b001100, 6'd0, 6'd10, 1'b0, 1'b0);
        run_alu(6'b001101, 6'd0, 6'd11, 1'b0, 1'b0);
        run_alu(6'b001110, 6'd0, 6'd12, 1'b0, 1'b0);
        run_mem(1'b0, 1, 3);                               // sw with waits

        while (exp_instret != 3'd7) run_j();
        run_j();
        check_val("instret_wrap", 32'(bus.instret), 32'd0);

        // Reset while a store is waiting on memory.
        do_fetch(0, 6'b101011, 6'd0);
        e = base(4'd2);
        e.src_a = 1'b1;
        e.src_b = 2'b10;
        e.alu_op = 6'd15;
        drive(1'b0, 1'b0, 1'b0, e);
        e = base(4'd5);
        e.iord = 1'b1;
        e.mem_write = 1'b1;
        drive(1'b0, 1'b0, 1'b0, e);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, base(4'd5));
        exp_instret = '0;
        exp_cause = 1'b0;
        drive(1'b0, 1'b0, 1'b0, base(4'd0));
        reset = 1'b0;
        run_j();
        check_val("instret_after_reset", 32'(bus.instret), 32'd1);

        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
